// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: captures one request, drives a valid/ack data-memory
// port (byte enables or read-modify-write), extends load data and reports errors.
module load_store_unit #(
    parameter int unsigned XLEN    = 32,
    parameter bit          BYTE_EN = 1'b1,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_store,
    input  logic [2:0]                 req_funct3,
    input  logic [31:0]                req_addr,
    input  logic [XLEN-1:0]            req_wdata,
    output logic                       resp_valid,
    output logic [XLEN-1:0]            resp_rdata,
    output logic [1:0]                 resp_err,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [31-$clog2(XLEN/8):0] mem_addr,
    output logic [XLEN-1:0]            mem_wdata,
    output logic [XLEN/8-1:0]          mem_be,
    input  logic                       mem_ack,
    input  logic [XLEN-1:0]            mem_rdata
);

    localparam int unsigned NB  = XLEN / 8;
    localparam int unsigned OFF = $clog2(NB);
    localparam logic [15:0] TLAST = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP} state_t;

    state_t              state_q;
    logic [OFF-1:0]      lane_q;
    logic [2:0]          funct3_q;
    logic [NB-1:0]       lanes_q;
    logic [XLEN-1:0]     wsh_q;
    logic [15:0]         wait_q;
    logic                resp_valid_q;
    logic [XLEN-1:0]     resp_rdata_q;
    logic [1:0]          resp_err_q;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [31-OFF:0]     mem_addr_q;
    logic [XLEN-1:0]     mem_wdata_q;
    logic [NB-1:0]       mem_be_q;

    logic                illegal_d;
    logic                misal_d;
    logic                full_d;
    logic [NB-1:0]       be_d;
    logic [XLEN-1:0]     wsh_d;
    logic [XLEN-1:0]     rsh_d;
    logic [XLEN-1:0]     load_d;
    logic [XLEN-1:0]     merge_d;

    always_comb begin
        illegal_d = (req_funct3 == 3'b111) || (req_store && req_funct3[2]) ||
                    ((XLEN == 32) && ((req_funct3 == 3'b011) || (req_funct3 == 3'b110)));
        misal_d = 1'b0;
        be_d    = '1;
        case (req_funct3[1:0])
            2'b00: be_d = NB'(1);
            2'b01: begin be_d = NB'(3);  misal_d = req_addr[0];          end
            2'b10: begin be_d = NB'(15); misal_d = (req_addr[1:0] != '0); end
            default: misal_d = (req_addr[2:0] != '0);
        endcase
        be_d   = be_d << req_addr[OFF-1:0];
        full_d = (XLEN == 64) ? (req_funct3[1:0] == 2'b11) : (req_funct3[1:0] == 2'b10);
        wsh_d  = req_wdata << {req_addr[OFF-1:0], 3'b000};
    end

    always_comb begin
        rsh_d = mem_rdata >> {lane_q, 3'b000};
        case (funct3_q)
            3'b000:  load_d = XLEN'($signed(rsh_d[7:0]));
            3'b001:  load_d = XLEN'($signed(rsh_d[15:0]));
            3'b010:  load_d = XLEN'($signed(rsh_d[31:0]));
            3'b100:  load_d = XLEN'(rsh_d[7:0]);
            3'b101:  load_d = XLEN'(rsh_d[15:0]);
            3'b110:  load_d = XLEN'(rsh_d[31:0]);
            default: load_d = rsh_d;
        endcase
        for (int unsigned i = 0; i < NB; i++) begin
            merge_d[8*i +: 8] = lanes_q[i] ? wsh_q[8*i +: 8] : mem_rdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            lane_q       <= '0;
            funct3_q     <= '0;
            lanes_q      <= '0;
            wsh_q        <= '0;
            wait_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        lane_q     <= req_addr[OFF-1:0];
                        funct3_q   <= req_funct3;
                        lanes_q    <= be_d;
                        wsh_q      <= wsh_d;
                        wait_q     <= '0;
                        mem_addr_q <= req_addr[31:OFF];
                        if (illegal_d || misal_d) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= '0;
                            resp_err_q   <= illegal_d ? 2'b11 : 2'b01;
                        end else if (!req_store) begin
                            state_q     <= LOAD;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= 1'b0;
                            mem_be_q    <= be_d;
                            mem_wdata_q <= '0;
                        end else if (BYTE_EN || full_d) begin
                            state_q     <= STORE;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= 1'b1;
                            mem_be_q    <= be_d;
                            mem_wdata_q <= wsh_d;
                        end else begin
                            state_q     <= RMW_RD;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= 1'b0;
                            mem_be_q    <= '1;
                            mem_wdata_q <= '0;
                        end
                    end
                end
                LOAD, STORE, RMW_RD, RMW_WR: begin
                    if (mem_ack) begin
                        wait_q <= '0;
                        if (state_q == RMW_RD) begin
                            // mem_req stays high so the write phase follows without a gap
                            state_q     <= RMW_WR;
                            mem_we_q    <= 1'b1;
                            mem_wdata_q <= merge_d;
                        end else begin
                            state_q      <= RESP;
                            mem_req_q    <= 1'b0;
                            mem_we_q     <= 1'b0;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 2'b00;
                            resp_rdata_q <= (state_q == LOAD) ? load_d : '0;
                        end
                    end else if (wait_q == TLAST) begin
                        state_q      <= RESP;
                        wait_q       <= '0;
                        mem_req_q    <= 1'b0;
                        mem_we_q     <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 2'b10;
                        resp_rdata_q <= '0;
                    end else begin
                        wait_q <= wait_q + 16'd1;
                    end
                end
                RESP: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                    resp_rdata_q <= '0;
                    resp_err_q   <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_be     = mem_be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: three configurations (32-bit byte-enable, 32-bit RMW, 64-bit)
// against a byte-array memory model and a transaction-level reference.
module tb_load_store_unit;

    logic clk;
    logic rst;
    logic        rv_i   [3];
    logic        rdy    [3];
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic        rv_o   [3];
    logic [63:0] rdata_o[3];
    logic [1:0]  err_o  [3];
    logic        mreq   [3];
    logic        mwe    [3];
    logic [31:0] maddr  [3];
    logic [63:0] mwdata [3];
    logic [7:0]  mbe    [3];
    logic        ack    [3];
    logic [63:0] mrd    [3];

    logic [31:0] d0_rdata, d1_rdata, d0_mwd, d1_mwd;
    logic [29:0] d0_maddr, d1_maddr;
    logic [28:0] d2_maddr;
    logic [3:0]  d0_mbe, d1_mbe;

    assign rdata_o[0] = {32'h0, d0_rdata};
    assign rdata_o[1] = {32'h0, d1_rdata};
    assign mwdata[0]  = {32'h0, d0_mwd};
    assign mwdata[1]  = {32'h0, d1_mwd};
    assign maddr[0]   = {2'b00, d0_maddr};
    assign maddr[1]   = {2'b00, d1_maddr};
    assign maddr[2]   = {3'b000, d2_maddr};
    assign mbe[0]     = {4'h0, d0_mbe};
    assign mbe[1]     = {4'h0, d1_mbe};

    load_store_unit #(.XLEN(32), .BYTE_EN(1'b1), .TIMEOUT(4)) u_d0 (
        .clk(clk), .rst(rst), .req_valid(rv_i[0]), .req_ready(rdy[0]), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
        .resp_valid(rv_o[0]), .resp_rdata(d0_rdata), .resp_err(err_o[0]), .mem_req(mreq[0]),
        .mem_we(mwe[0]), .mem_addr(d0_maddr), .mem_wdata(d0_mwd), .mem_be(d0_mbe),
        .mem_ack(ack[0]), .mem_rdata(mrd[0][31:0]));

    load_store_unit #(.XLEN(32), .BYTE_EN(1'b0), .TIMEOUT(4)) u_d1 (
        .clk(clk), .rst(rst), .req_valid(rv_i[1]), .req_ready(rdy[1]), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
        .resp_valid(rv_o[1]), .resp_rdata(d1_rdata), .resp_err(err_o[1]), .mem_req(mreq[1]),
        .mem_we(mwe[1]), .mem_addr(d1_maddr), .mem_wdata(d1_mwd), .mem_be(d1_mbe),
        .mem_ack(ack[1]), .mem_rdata(mrd[1][31:0]));

    load_store_unit #(.XLEN(64), .BYTE_EN(1'b1), .TIMEOUT(6)) u_d2 (
        .clk(clk), .rst(rst), .req_valid(rv_i[2]), .req_ready(rdy[2]), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv_o[2]), .resp_rdata(rdata_o[2]), .resp_err(err_o[2]), .mem_req(mreq[2]),
        .mem_we(mwe[2]), .mem_addr(d2_maddr), .mem_wdata(mwdata[2]), .mem_be(mbe[2]),
        .mem_ack(ack[2]), .mem_rdata(mrd[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [7:0]  dmem [3][1024];
    logic [7:0]  rmem [3][1024];
    int          wait_cfg;
    logic        ack_en;
    logic        stray_ack;
    int          wcnt [3];
    logic [7:0]  lw_be  [3];
    logic [63:0] lw_data[3];
    int          n_chk;
    int          n_fail;
    logic [63:0] lrd;
    logic [1:0]  lerr;
    logic [7:0]  fbe;
    logic [31:0] faddr;

    function automatic int xl(input int d);
        return (d == 2) ? 64 : 32;
    endfunction

    // Memory environment: acks after wait_cfg idle cycles, applies writes under mem_be.
    initial begin
        for (int d = 0; d < 3; d++) begin
            ack[d] = 1'b0;
            mrd[d] = '0;
            wcnt[d] = 0;
            lw_be[d] = '0;
            lw_data[d] = '0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (stray_ack) begin
                    ack[d] = 1'b1;
                end else if (mreq[d] && ack_en) begin
                    if (wcnt[d] >= wait_cfg) begin
                        int nb;
                        int ba;
                        nb = xl(d) / 8;
                        ba = int'(maddr[d]) * nb;
                        ack[d] = 1'b1;
                        wcnt[d] = 0;
                        if (mwe[d]) begin
                            for (int i = 0; i < nb; i++)
                                if (mbe[d][i]) dmem[d][ba+i] = mwdata[d][8*i +: 8];
                            lw_be[d] = mbe[d];
                            lw_data[d] = mwdata[d];
                        end else begin
                            mrd[d] = '0;
                            for (int i = 0; i < nb; i++) mrd[d][8*i +: 8] = dmem[d][ba+i];
                        end
                    end else begin
                        ack[d] = 1'b0;
                        wcnt[d]++;
                    end
                end else begin
                    ack[d] = 1'b0;
                    wcnt[d] = 0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] exp_err(input int d, input logic st, input logic [2:0] f3,
                                           input logic [31:0] a);
        int sz;
        sz = 1 << f3[1:0];
        if (f3 == 3'b111 || (st && f3[2]) || (xl(d) == 32 && (f3 == 3'b011 || f3 == 3'b110)))
            return 2'b11;
        if ((int'(a) % sz) != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [63:0] load_model(input int d, input logic [2:0] f3, input logic [31:0] a);
        int sz;
        logic [63:0] v;
        sz = 1 << f3[1:0];
        v = '0;
        for (int i = 0; i < sz; i++) v = v | (64'(rmem[d][int'(a)+i]) << (8*i));
        if (!f3[2] && sz < 8 && v[8*sz-1]) v = v | (~64'h0 << (8*sz));
        if (xl(d) == 32) v = v & 64'hFFFF_FFFF;
        return v;
    endfunction

    function automatic logic [63:0] pack_word(input int d, input logic model, input logic [31:0] a);
        int nb;
        int wb;
        logic [63:0] v;
        nb = xl(d) / 8;
        wb = int'(a) - (int'(a) % nb);
        v = '0;
        for (int i = 0; i < nb; i++)
            v[8*i +: 8] = model ? rmem[d][wb+i] : dmem[d][wb+i];
        return v;
    endfunction

    task automatic issue(input int d, input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [63:0] wd);
        int g;
        g = 0;
        @(negedge clk);
        while (!rdy[d] && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("ready_before_req", 64'(rdy[d]), 64'd1);
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        rv_i[d]    = 1'b1;
        @(posedge clk);
        #1 rv_i[d] = 1'b0;
    endtask

    task automatic do_txn(input int d, input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [63:0] wd, input int w, input logic to);
        logic [1:0]  e;
        logic        rmw;
        logic        got;
        int          sz, cyc, mr, exp_cyc, exp_mr;
        logic [63:0] exp_rd;
        wait_cfg = w;
        ack_en   = !to;
        issue(d, st, f3, a, wd);
        e   = exp_err(d, st, f3, a);
        sz  = 1 << f3[1:0];
        rmw = st && (d == 1) && (8*sz != xl(d));
        if (e != 2'b00) begin
            exp_cyc = 1; exp_mr = 0;
        end else if (to) begin
            e = 2'b10; exp_cyc = (d == 2 ? 6 : 4) + 1; exp_mr = exp_cyc - 1;
        end else if (rmw) begin
            exp_cyc = 3 + 2*w; exp_mr = 2*w + 2;
        end else begin
            exp_cyc = 2 + w; exp_mr = w + 1;
        end
        exp_rd = (e == 2'b00 && !st) ? load_model(d, f3, a) : 64'h0;
        cyc = 0; mr = 0; got = 1'b0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (mreq[d]) mr++;
            if (cyc == 1) begin
                fbe = mbe[d];
                faddr = maddr[d];
            end
            if (rv_o[d]) begin
                got = 1'b1;
                lrd = rdata_o[d];
                lerr = err_o[d];
            end
        end
        check("resp_seen", 64'(got), 64'd1);
        check("resp_cycle", 64'(cyc), 64'(exp_cyc));
        check("mem_req_cycles", 64'(mr), 64'(exp_mr));
        check("resp_err", 64'(lerr), 64'(e));
        check("resp_rdata", lrd, exp_rd);
        @(negedge clk);
        check("resp_one_pulse", 64'(rv_o[d]), 64'd0);
        check("ready_after", 64'(rdy[d]), 64'd1);
        if (st && e == 2'b00)
            for (int i = 0; i < sz; i++) rmem[d][int'(a)+i] = wd[8*i +: 8];
        if (st) check("mem_word", pack_word(d, 1'b0, a), pack_word(d, 1'b1, a));
        ack_en = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0;
        n_fail = 0;
        wait_cfg = 0;
        ack_en = 1'b1;
        stray_ack = 1'b0;
        req_store = 1'b0;
        req_funct3 = '0;
        req_addr = '0;
        req_wdata = '0;
        for (int d = 0; d < 3; d++) begin
            rv_i[d] = 1'b0;
            for (int i = 0; i < 1024; i++) begin
                logic [7:0] b;
                b = 8'($urandom);
                dmem[d][i] = b;
                rmem[d][i] = b;
            end
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("rst_ready", 64'(rdy[d]), 64'd1);
            check("rst_resp_valid", 64'(rv_o[d]), 64'd0);
            check("rst_resp_rdata", rdata_o[d], 64'd0);
            check("rst_resp_err", 64'(err_o[d]), 64'd0);
            check("rst_mem_req", 64'(mreq[d]), 64'd0);
            check("rst_mem_we", 64'(mwe[d]), 64'd0);
            check("rst_mem_addr", 64'(maddr[d]), 64'd0);
            check("rst_mem_wdata", mwdata[d], 64'd0);
            check("rst_mem_be", 64'(mbe[d]), 64'd0);
        end
        rst = 1'b0;

        // 32-bit byte-enable store then sign/zero-extended loads
        do_txn(0, 1'b1, 3'b010, 32'h100, 64'hDEADBEEF, 0, 1'b0);
        check("sw_be", 64'(fbe), 64'hF);
        check("sw_addr", 64'(faddr), 64'h40);
        do_txn(0, 1'b0, 3'b000, 32'h103, 64'h0, 0, 1'b0);
        check("lb_value", lrd, 64'hFFFFFFDE);
        do_txn(0, 1'b0, 3'b100, 32'h103, 64'h0, 0, 1'b0);
        check("lbu_value", lrd, 64'h000000DE);
        do_txn(0, 1'b0, 3'b001, 32'h102, 64'h0, 0, 1'b0);
        check("lh_value", lrd, 64'hFFFFDEAD);

        // read-modify-write byte store
        {dmem[1][259], dmem[1][258], dmem[1][257], dmem[1][256]} = 32'h11223344;
        {rmem[1][259], rmem[1][258], rmem[1][257], rmem[1][256]} = 32'h11223344;
        do_txn(1, 1'b1, 3'b000, 32'h101, 64'h55, 0, 1'b0);
        check("rmw_be", 64'(lw_be[1]), 64'hF);
        check("rmw_wdata", lw_data[1], 64'h11225544);

        // errors at acceptance
        do_txn(0, 1'b0, 3'b010, 32'h102, 64'h0, 0, 1'b0);
        check("misaligned_err", 64'(lerr), 64'h1);
        do_txn(0, 1'b0, 3'b011, 32'h100, 64'h0, 0, 1'b0);
        check("illegal_err", 64'(lerr), 64'h3);

        // timeout, then stray acks while idle, then a normal access
        do_txn(0, 1'b0, 3'b010, 32'h200, 64'h0, 0, 1'b1);
        check("timeout_err", 64'(lerr), 64'h2);
        @(posedge clk);
        #1 stray_ack = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("stray_ack_no_resp", 64'(rv_o[0]), 64'd0);
            check("stray_ack_no_req", 64'(mreq[0]), 64'd0);
        end
        stray_ack = 1'b0;
        do_txn(0, 1'b0, 3'b010, 32'h100, 64'h0, 0, 1'b0);
        check("after_timeout_lw", lrd, 64'hDEADBEEF);

        // three wait states
        do_txn(0, 1'b0, 3'b010, 32'h100, 64'h0, 3, 1'b0);

        // reset during a wait-stated load
        begin
            logic seen;
            wait_cfg = 3;
            issue(0, 1'b0, 3'b010, 32'h100, 64'h0);
            @(negedge clk);
            check("pre_rst_mem_req", 64'(mreq[0]), 64'd1);
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            check("rst_mid_mem_req", 64'(mreq[0]), 64'd0);
            check("rst_mid_resp_valid", 64'(rv_o[0]), 64'd0);
            check("rst_mid_ready", 64'(rdy[0]), 64'd1);
            rst = 1'b0;
            seen = 1'b0;
            repeat (6) begin
                @(negedge clk);
                if (rv_o[0]) seen = 1'b1;
            end
            check("rst_mid_no_resp", 64'(seen), 64'd0);
        end

        // 64-bit doubleword store and narrower loads
        do_txn(2, 1'b1, 3'b011, 32'h8, 64'h0123456789ABCDEF, 0, 1'b0);
        do_txn(2, 1'b0, 3'b110, 32'hC, 64'h0, 0, 1'b0);
        check("lwu64", lrd, 64'h0000000001234567);
        do_txn(2, 1'b0, 3'b010, 32'hC, 64'h0, 0, 1'b0);
        check("lw64", lrd, 64'h0000000001234567);
        do_txn(2, 1'b0, 3'b001, 32'hE, 64'h0, 0, 1'b0);
        check("lh64", lrd, 64'h0000000000000123);

        // randomized traffic
        for (int n = 0; n < 200; n++) begin
            int d;
            logic st;
            logic [2:0] f3;
            logic [31:0] a;
            int sz;
            d  = int'($urandom_range(0, 2));
            st = 1'($urandom);
            f3 = 3'($urandom);
            sz = 1 << f3[1:0];
            a  = $urandom_range(0, 1015);
            if (($urandom % 4) != 0) a = a & ~(32'(sz) - 32'd1);
            do_txn(d, st, f3, a, {$urandom, $urandom}, int'($urandom_range(0, 3)),
                   (($urandom % 16) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
